// File: rtl/tb_mem_req_buffer_if.sv
// rtl/tb_mem_req_buffer_if.sv - request, SRAM and response channels of the memory front-end
interface tb_mem_req_buffer_if #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 64,
  parameter int NumWords  = 16384
);
  // Upstream request channel
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_we;
  logic [AddrWidth-1:0]          req_addr;
  logic [DataWidth/8-1:0]        req_be;
  logic [DataWidth-1:0]          req_wdata;

  // Downstream SRAM port (read data one cycle after the strobe)
  logic                          mem_req;
  logic                          mem_we;
  logic [$clog2(NumWords)-1:0]   mem_addr;
  logic [DataWidth/8-1:0]        mem_be;
  logic [DataWidth-1:0]          mem_wdata;
  logic [DataWidth-1:0]          mem_rdata;

  // Upstream response channel
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_we;
  logic [DataWidth-1:0]          rsp_rdata;
  logic                          rsp_err;

  // Buffer side
  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata,
    output rsp_valid, rsp_we, rsp_rdata, rsp_err,
    input  rsp_ready
  );

  // Requester / SRAM model side
  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata,
    input  rsp_valid, rsp_we, rsp_rdata, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/tb_mem_req_buffer.sv
// rtl/tb_mem_req_buffer.sv - buffered memory front-end for a 1-cycle SRAM; range check under TB_MEM_ADDR_CHECK_EN
module tb_mem_req_buffer #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 64,
  parameter int NumWords  = 16384,
  parameter int Depth     = 4,
  parameter int Latency   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  tb_mem_req_buffer_if.slave bus
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int OffWidth = $clog2(BeWidth);
  localparam int IdxWidth = $clog2(NumWords);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);
  localparam int RspWidth = DataWidth + 2;
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Request FIFO
  logic                 rq_we    [Depth];
  logic [AddrWidth-1:0] rq_addr  [Depth];
  logic [BeWidth-1:0]   rq_be    [Depth];
  logic [DataWidth-1:0] rq_wdata [Depth];
  logic [PtrWidth-1:0]  rq_wr_ptr, rq_rd_ptr;
  logic [CntWidth-1:0]  rq_count;
  logic                 rq_full, rq_empty, rq_push, rq_pop;

  // Issue / outstanding tracking
  logic [CntWidth-1:0]  out_count;
  logic                 issue, head_err, rsp_fire;
  logic                 head_we;
  logic [AddrWidth-1:0] head_addr;
  logic                 unused_addr;

  // Response pipeline
  logic                 pend_valid, pend_we, pend_err;
  logic [DataWidth-1:0] stage0_data;
  logic [Latency:0]     st_valid;
  logic [RspWidth-1:0]  st_data [Latency+1];

  // Response FIFO
  logic [RspWidth-1:0]  rs_data [Depth];
  logic [PtrWidth-1:0]  rs_wr_ptr, rs_rd_ptr;
  logic [CntWidth-1:0]  rs_count;
  logic                 rs_push;
  logic [RspWidth-1:0]  rs_head;

  assign rq_full       = (rq_count == DepthCnt);
  assign rq_empty      = (rq_count == '0);
  assign bus.req_ready = !rq_full;
  assign rq_push       = bus.req_valid && !rq_full;

  assign head_we   = rq_we[rq_rd_ptr];
  assign head_addr = rq_addr[rq_rd_ptr];
  // Offset bits and (without the range check) the upper bits are ignored by design.
  assign unused_addr = ^head_addr;

`ifdef TB_MEM_ADDR_CHECK_EN
  assign head_err = |head_addr[AddrWidth-1:OffWidth+IdxWidth];
`else
  assign head_err = 1'b0;
`endif

  // An out-of-range request still takes an issue slot so ordering and the
  // outstanding limit behave identically; it just never strobes the SRAM.
  assign issue         = !rq_empty && (out_count < DepthCnt);
  assign rq_pop        = issue;
  assign bus.mem_req   = issue && !head_err;
  assign bus.mem_we    = head_we;
  assign bus.mem_addr  = head_addr[OffWidth +: IdxWidth];
  assign bus.mem_be    = rq_be[rq_rd_ptr];
  assign bus.mem_wdata = rq_wdata[rq_rd_ptr];

  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

  // Request FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rq_wr_ptr <= '0;
      rq_rd_ptr <= '0;
      rq_count  <= '0;
    end else begin
      if (rq_push) begin
        rq_we[rq_wr_ptr]    <= bus.req_we;
        rq_addr[rq_wr_ptr]  <= bus.req_addr;
        rq_be[rq_wr_ptr]    <= bus.req_be;
        rq_wdata[rq_wr_ptr] <= bus.req_wdata;
        rq_wr_ptr           <= next_ptr(rq_wr_ptr);
      end
      if (rq_pop) begin
        rq_rd_ptr <= next_ptr(rq_rd_ptr);
      end
      case ({rq_push, rq_pop})
        2'b10:   rq_count <= rq_count + CntWidth'(1);
        2'b01:   rq_count <= rq_count - CntWidth'(1);
        default: rq_count <= rq_count;
      endcase
    end
  end

  // Issued-but-not-accepted counter; bounds everything downstream of issue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_count <= '0;
    end else begin
      case ({issue, rsp_fire})
        2'b10:   out_count <= out_count + CntWidth'(1);
        2'b01:   out_count <= out_count - CntWidth'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // Remember what was issued while the SRAM produces its read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= issue;
      pend_we    <= head_we;
      pend_err   <= head_err;
    end
  end

  assign stage0_data = pend_err ? '1 : (pend_we ? '0 : bus.mem_rdata);

  // Stage 0 capture followed by Latency delay stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_valid <= '0;
    end else begin
      st_valid[0] <= pend_valid;
      for (int i = 1; i <= Latency; i++) begin
        st_valid[i] <= st_valid[i-1];
      end
    end
    st_data[0] <= {pend_we, pend_err, stage0_data};
    for (int i = 1; i <= Latency; i++) begin
      st_data[i] <= st_data[i-1];
    end
  end

  assign rs_push = st_valid[Latency];

  // Response FIFO; cannot overflow because out_count caps entries in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs_wr_ptr <= '0;
      rs_rd_ptr <= '0;
      rs_count  <= '0;
    end else begin
      if (rs_push) begin
        rs_data[rs_wr_ptr] <= st_data[Latency];
        rs_wr_ptr          <= next_ptr(rs_wr_ptr);
      end
      if (rsp_fire) begin
        rs_rd_ptr <= next_ptr(rs_rd_ptr);
      end
      case ({rs_push, rsp_fire})
        2'b10:   rs_count <= rs_count + CntWidth'(1);
        2'b01:   rs_count <= rs_count - CntWidth'(1);
        default: rs_count <= rs_count;
      endcase
    end
  end

  assign rs_head       = rs_data[rs_rd_ptr];
  assign bus.rsp_valid = (rs_count != '0);
  assign bus.rsp_we    = bus.rsp_valid && rs_head[RspWidth-1];
  assign bus.rsp_err   = bus.rsp_valid && rs_head[RspWidth-2];
  assign bus.rsp_rdata = bus.rsp_valid ? rs_head[DataWidth-1:0] : '0;
endmodule

// File: tb/tb_tb_mem_req_buffer.sv
// tb/tb_tb_mem_req_buffer.sv - scoreboard bench for tb_mem_req_buffer with an SRAM model
module tb_tb_mem_req_buffer;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int NW = 16384;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tb_mem_req_buffer_if #(.AddrWidth(AW), .DataWidth(DW), .NumWords(NW)) bus();

  tb_mem_req_buffer #(
    .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .Depth(DEPTH), .Latency(LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   ref_mem [longint unsigned];
  logic [DW-1:0]   sram [NW];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_pulses = 0, mem_run = 0, max_mem_run = 0;
  int rsp_count = 0, rsp_valid_cycles = 0, last_lat = 0;
  logic [DW-1:0] last_rdata = '0;
  logic last_err = 1'b0;
  bit   rr_random = 1'b0;
  logic rr_value = 1'b1;
  bit   hold_v = 1'b0;
  logic hold_we, hold_err;
  logic [DW-1:0] hold_rdata;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // SRAM model: write at the edge, read data valid the following cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req) begin
      if (bus.mem_we) begin
        for (int b = 0; b < BW; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  // Response ready driver
  always @(posedge clk) begin
    #1;
    bus.rsp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_value;
  end

  // Scoreboard: push expectation on request accept, pop/compare on response accept
  always @(negedge clk) begin
    exp_t e;
    longint unsigned word;
    logic [DW-1:0] cur;
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
      mem_run = 0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        word = (64'(bus.req_addr) >> $clog2(BW)) % 64'(NW);
        e.we = bus.req_we;
        e.cyc = cyc;
`ifdef TB_MEM_ADDR_CHECK_EN
        e.err = (64'(bus.req_addr) >= 64'(NW) * 64'(BW));
`else
        e.err = 1'b0;
`endif
        cur = ref_mem.exists(word) ? ref_mem[word] : '0;
        if (e.err) begin
          e.rdata = '1;
        end else if (bus.req_we) begin
          for (int b = 0; b < BW; b++)
            if (bus.req_be[b]) cur[8*b +: 8] = bus.req_wdata[8*b +: 8];
          ref_mem[word] = cur;
          e.rdata = '0;
        end else begin
          e.rdata = cur;
        end
        exp_q.push_back(e);
      end

      if (hold_v) begin
        chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'(1));
        chk("rsp_hold_we", 64'(bus.rsp_we), 64'(hold_we));
        chk("rsp_hold_rdata", bus.rsp_rdata, hold_rdata);
        chk("rsp_hold_err", 64'(bus.rsp_err), 64'(hold_err));
      end

      if (bus.rsp_valid) rsp_valid_cycles++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_we", 64'(bus.rsp_we), 64'(e.we));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          last_lat = cyc - e.cyc;
          last_rdata = bus.rsp_rdata;
          last_err = bus.rsp_err;
          rsp_count++;
        end
      end
      hold_v = bus.rsp_valid && !bus.rsp_ready;
      hold_we = bus.rsp_we;
      hold_err = bus.rsp_err;
      hold_rdata = bus.rsp_rdata;

      if (bus.mem_req) begin
        mem_pulses++;
        mem_run++;
        if (mem_run > max_mem_run) max_mem_run = mem_run;
      end else begin
        mem_run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [63:0] addr, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd);
    bit ok = 1'b0;
    logic acc;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr[AW-1:0];
    bus.req_be = be;
    bus.req_wdata = wd;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      acc = bus.req_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 3000; n++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(name, 64'(exp_q.size()), 64'(0));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p0, r0, v0;
    logic acc;
    logic [63:0] a;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_be = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NW; i++) sram[i] = '0;

    repeat (3) step();
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'(1));
    chk("reset_mem_req", 64'(bus.mem_req), 64'(0));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_we", 64'(bus.rsp_we), 64'(0));
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'(0));
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
    step();
    rst = 1'b0;
    rr_value = 1'b1;
    repeat (2) step();

    // Full write then read-back, with latency of the read
    send(1'b1, 64'h100, 8'hFF, 64'h1122334455667788);
    send(1'b0, 64'h100, 8'h00, 64'h0);
    wait_idle("idle_raw");
    chk("raw_rdata", last_rdata, 64'h1122334455667788);
    chk("read_latency", 64'(last_lat), 64'(4 + LAT));

    // Partial byte-enable write over zero
    send(1'b1, 64'h8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    send(1'b0, 64'h8, 8'h00, 64'h0);
    wait_idle("idle_partial");
    chk("partial_rdata", last_rdata, 64'h00000000_BBBBBBBB);

    // Back-pressure: Depth entries queued plus Depth outstanding, then stall
    for (int i = 0; i < 8; i++) send(1'b1, 64'h200 + 64'(8 * i), 8'hFF, {$urandom, $urandom});
    wait_idle("idle_prefill");
    rr_value = 1'b0;
    repeat (2) step();
    p0 = mem_pulses;
    r0 = rsp_count;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      a = 64'h200 + 64'(8 * k);
      bus.req_addr = a[AW-1:0];
      @(negedge clk);
      acc = bus.req_ready;
      step();
      if (acc) k++;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.req_ready), 64'(0));
    chk("bp_accepted", 64'(k), 64'(2 * DEPTH));
    chk("bp_mem_pulses", 64'(mem_pulses - p0), 64'(DEPTH));
    step();
    rr_value = 1'b1;
    wait_idle("idle_bp");
    chk("bp_responses", 64'(rsp_count - r0), 64'(2 * DEPTH));

    // Reset with requests in flight
    rr_value = 1'b0;
    repeat (2) step();
    send(1'b0, 64'h200, 8'h00, 64'h0);
    send(1'b0, 64'h208, 8'h00, 64'h0);
    send(1'b0, 64'h210, 8'h00, 64'h0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.req_ready), 64'(1));
    rr_value = 1'b1;
    v0 = rsp_valid_cycles;
    repeat (10) step();
    chk("no_rsp_after_reset", 64'(rsp_valid_cycles - v0), 64'(0));
    send(1'b0, 64'h100, 8'h00, 64'h0);
    wait_idle("idle_after_reset");
    chk("post_reset_rdata", last_rdata, 64'h1122334455667788);

    // Out-of-range address
    send(1'b1, 64'h0, 8'hFF, 64'hCAFE0000_0000BEEF);
    wait_idle("idle_word0");
    p0 = mem_pulses;
    send(1'b0, 64'(NW) * 64'(BW), 8'h00, 64'h0);
    wait_idle("idle_oob");
`ifdef TB_MEM_ADDR_CHECK_EN
    chk("oob_err", 64'(last_err), 64'(1));
    chk("oob_rdata", last_rdata, 64'hFFFFFFFF_FFFFFFFF);
    chk("oob_mem_pulses", 64'(mem_pulses - p0), 64'(0));
`else
    chk("oob_err", 64'(last_err), 64'(0));
    chk("oob_rdata", last_rdata, 64'hCAFE0000_0000BEEF);
    chk("oob_mem_pulses", 64'(mem_pulses - p0), 64'(1));
`endif

    // Streaming reads: issue runs are capped by the outstanding limit
    max_mem_run = 0;
    r0 = rsp_count;
    for (int i = 0; i < 16; i++) send(1'b0, 64'h300 + 64'(8 * i), 8'h00, 64'h0);
    wait_idle("idle_stream");
    chk("stream_mem_run", 64'(max_mem_run), 64'((DEPTH >= LAT + 4) ? 16 : DEPTH));
    chk("stream_responses", 64'(rsp_count - r0), 64'(16));

    // Randomized traffic against the reference model
    rr_random = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 64'($urandom_range(0, 15) * BW + $urandom_range(0, BW - 1));
      if ($urandom_range(0, 7) == 0) a = a + 64'(NW) * 64'(BW) * 64'($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), a, BW'($urandom), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle("idle_random");
    rr_random = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
